// File: rtl/i3c_pkg.sv
// Shared types and constants for the legacy-I2C target responder.
// Imported by the interface, the event detector and the top.
package i3c_pkg;
    localparam int I2C_ADDR_WIDTH = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } tgt_state_e;
endpackage

// File: rtl/i3c_i2c_target_responder_if.sv
// Bus pins plus RX/TX byte streams and status of the I2C target.
// master = controller/environment side, slave = the target block.
interface i3c_i2c_target_responder_if;
    import i3c_pkg::*;

    logic                      scl_i;
    logic                      sda_i;
    logic                      sda_o;
    logic                      enable_i;
    logic [I2C_ADDR_WIDTH-1:0] target_addr_i;
    logic [7:0]                rx_data_o;
    logic                      rx_valid_o;
    logic                      rx_ready_i;
    logic [7:0]                tx_data_i;
    logic                      tx_valid_i;
    logic                      tx_ready_o;
    logic                      tx_underrun_o;
    logic                      addr_match_o;
    logic                      rnw_o;
    logic                      start_det_o;
    logic                      stop_det_o;
    logic                      busy_o;

    modport master (
        output scl_i, sda_i, enable_i, target_addr_i,
        output rx_ready_i, tx_data_i, tx_valid_i,
        input  sda_o, rx_data_o, rx_valid_o, tx_ready_o,
        input  tx_underrun_o, addr_match_o, rnw_o,
        input  start_det_o, stop_det_o, busy_o
    );

    modport slave (
        input  scl_i, sda_i, enable_i, target_addr_i,
        input  rx_ready_i, tx_data_i, tx_valid_i,
        output sda_o, rx_data_o, rx_valid_o, tx_ready_o,
        output tx_underrun_o, addr_match_o, rnw_o,
        output start_det_o, stop_det_o, busy_o
    );
endinterface

// File: rtl/i3c_bus_event_detect.sv
// Synchronizes SCL/SDA and derives edge, START and STOP events
// by comparing the synchronized value against the previous sample.
module i3c_bus_event_detect #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    localparam int Stages = (SyncStages < 2) ? 2 : SyncStages;

    logic [Stages-1:0] scl_sync;
    logic [Stages-1:0] sda_sync;
    logic              scl_q;
    logic              sda_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[Stages-2:0], scl_i};
            sda_sync <= {sda_sync[Stages-2:0], sda_i};
            scl_q    <= scl_sync[Stages-1];
            sda_q    <= sda_sync[Stages-1];
        end
    end

    assign scl      = scl_sync[Stages-1];
    assign sda      = sda_sync[Stages-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SCL must be high on both samples so an SCL edge never fakes START/STOP
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;
endmodule

// File: rtl/i3c_i2c_target_responder.sv
// Legacy-I2C target with a 7-bit static address, open-drain SDA,
// write bytes to an RX stream and read bytes from a TX stream.
module i3c_i2c_target_responder
    import i3c_pkg::*;
#(
    parameter int         SyncStages    = 2,
    parameter logic [7:0] DefaultTxByte = 8'hFF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    i3c_i2c_target_responder_if.slave    bus
);
    logic ev_scl, ev_sda, ev_rise, ev_fall, ev_start, ev_stop;

    i3c_bus_event_detect #(.SyncStages(SyncStages)) u_evt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .scl_i    (bus.scl_i),
        .sda_i    (bus.sda_i),
        .scl      (ev_scl),
        .sda      (ev_sda),
        .scl_rise (ev_rise),
        .scl_fall (ev_fall),
        .start    (ev_start),
        .stop     (ev_stop)
    );

    tgt_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       ack_ph_q, ack_ph_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       sda_q, sda_d;
    logic       rnw_q, rnw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;
    logic       rx_valid_d, tx_ready_d, underrun_d;
    logic       match_d, start_d, stop_d;
    logic       rx_valid_q, tx_ready_q, underrun_q;
    logic       match_q, start_q, stop_q;

    logic       bit_rise;
    logic [7:0] in_byte;
    logic [7:0] load_byte;

    assign bit_rise  = ev_rise & ev_scl;
    assign in_byte   = {shift_q[6:0], ev_sda};
    assign load_byte = bus.tx_valid_i ? bus.tx_data_i : DefaultTxByte;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            ack_ph_q   <= 1'b0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            sda_q      <= 1'b1;
            rnw_q      <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            underrun_q <= 1'b0;
            match_q    <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_ph_q   <= ack_ph_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            sda_q      <= sda_d;
            rnw_q      <= rnw_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            underrun_q <= underrun_d;
            match_q    <= match_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ack_ph_d   = ack_ph_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        sda_d      = sda_q;
        rnw_d      = rnw_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        underrun_d = 1'b0;
        match_d    = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;

        if (ev_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
            sda_d     = 1'b1;
            start_d   = 1'b1;
            busy_d    = 1'b1;
        end else if (ev_stop) begin
            state_d  = ST_IDLE;
            ack_ph_d = 1'b0;
            sda_d    = 1'b1;
            stop_d   = 1'b1;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_WAIT_STOP: sda_d = 1'b1;
                ST_ADDR: if (bit_rise) begin
                    shift_d   = in_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (bus.enable_i &&
                            in_byte[7:1] == bus.target_addr_i) begin
                            state_d = ST_ADDR_ACK;
                            rnw_d   = in_byte[0];
                            match_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                // ack_ph marks that the ACK low is already on the bus
                ST_ADDR_ACK, ST_RX_ACK: if (ev_fall) begin
                    if (!ack_ph_q) begin
                        sda_d    = 1'b0;
                        ack_ph_d = 1'b1;
                    end else begin
                        ack_ph_d  = 1'b0;
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                        if (state_q == ST_RX_ACK || !rnw_q) begin
                            state_d = ST_RX_BYTE;
                        end else begin
                            state_d    = ST_TX_BYTE;
                            tx_shift_d = load_byte;
                            tx_ready_d = bus.tx_valid_i;
                            underrun_d = ~bus.tx_valid_i;
                            sda_d      = load_byte[7];
                        end
                    end
                end
                ST_RX_BYTE: if (bit_rise) begin
                    shift_d   = in_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (bus.rx_ready_i) begin
                            rx_data_d  = in_byte;
                            rx_valid_d = 1'b1;
                            state_d    = ST_RX_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                // here ack_ph means the loaded MSB still awaits its SCL fall
                ST_TX_BYTE: if (ev_fall) begin
                    if (ack_ph_q) begin
                        sda_d    = tx_shift_q[7];
                        ack_ph_d = 1'b0;
                    end else if (bit_cnt_q == 3'd7) begin
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_TX_ACK;
                    end else begin
                        sda_d      = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                end
                ST_TX_ACK: if (bit_rise) begin
                    if (!ev_sda) begin
                        state_d    = ST_TX_BYTE;
                        bit_cnt_d  = '0;
                        ack_ph_d   = 1'b1;
                        tx_shift_d = load_byte;
                        tx_ready_d = bus.tx_valid_i;
                        underrun_d = ~bus.tx_valid_i;
                    end else begin
                        state_d = ST_WAIT_STOP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.sda_o         = sda_q;
    assign bus.rnw_o         = rnw_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.tx_ready_o    = tx_ready_q;
    assign bus.tx_underrun_o = underrun_q;
    assign bus.addr_match_o  = match_q;
    assign bus.start_det_o   = start_q;
    assign bus.stop_det_o    = stop_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_i3c_i2c_target_responder.sv
// Bench: bit-banged I2C controller on an open-drain line against
// a transaction-level model of the target's expected responses.
module tb_i3c_i2c_target_responder;
    import i3c_pkg::*;

    localparam int         T      = 5;
    localparam logic [6:0] TARGET = 7'h50;
    localparam logic [7:0] DEF_TX = 8'hFF;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic ctrl_scl = 1'b1;
    logic ctrl_sda = 1'b1;

    int checks = 0;
    int failures = 0;

    int n_start = 0, n_stop = 0, n_match = 0, n_txr = 0, n_und = 0;
    logic [7:0] got_rx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] txq[$];
    logic [7:0] mq[$];
    logic [7:0] wbuf[4];
    logic       model_rnw = 1'b0;

    i3c_i2c_target_responder_if bus();

    assign bus.scl_i = ctrl_scl;
    assign bus.sda_i = ctrl_sda & bus.sda_o;

    i3c_i2c_target_responder #(
        .SyncStages    (2),
        .DefaultTxByte (DEF_TX)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.start_det_o)   n_start++;
        if (bus.stop_det_o)    n_stop++;
        if (bus.addr_match_o)  n_match++;
        if (bus.tx_underrun_o) n_und++;
        if (bus.rx_valid_o)    got_rx.push_back(bus.rx_data_o);
        if (bus.tx_ready_o) begin
            n_txr++;
            if (txq.size() != 0) void'(txq.pop_front());
        end
        bus.tx_valid_i = (txq.size() != 0);
        bus.tx_data_i  = (txq.size() != 0) ? txq[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ctrl_start();
        ctrl_sda = 1'b1; tick(T);
        ctrl_scl = 1'b1; tick(T);
        ctrl_sda = 1'b0; tick(T);
        ctrl_scl = 1'b0; tick(T);
    endtask

    task automatic ctrl_stop();
        ctrl_sda = 1'b0; tick(T);
        ctrl_scl = 1'b1; tick(T);
        ctrl_sda = 1'b1; tick(T);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        ctrl_sda = b;    tick(T);
        ctrl_scl = 1'b1; tick(T);
        r = bus.sda_i;   tick(T);
        ctrl_scl = 1'b0; tick(T);
    endtask

    task automatic xfer_byte(input logic [7:0] wb, input logic ack_in,
                             output logic [7:0] rb, output logic ack_seen);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(wb[i], r);
            rb[i] = r;
        end
        bit_xfer(ack_in, ack_seen);
    endtask

    task automatic push_tx(input logic [7:0] b);
        txq.push_back(b);
        mq.push_back(b);
    endtask

    task automatic check_rx();
        chk("rx_count", got_rx.size(), exp_rx.size());
        while (got_rx.size() != 0 && exp_rx.size() != 0)
            chk("rx_byte", got_rx.pop_front(), exp_rx.pop_front());
        got_rx.delete();
        exp_rx.delete();
    endtask

    // One controller transaction; expectations come from I2C rules only.
    task automatic xact(input logic [6:0] a, input logic rw, input int n,
                        input logic en, input logic rrdy,
                        input bit stop_after);
        int s0, p0, m0, t0, u0, e_txr, e_und;
        logic [7:0] rb, expb;
        logic ack, match;
        s0 = n_start; p0 = n_stop; m0 = n_match; t0 = n_txr; u0 = n_und;
        e_txr = 0; e_und = 0;
        bus.enable_i   = en;
        bus.rx_ready_i = rrdy;
        match = en && (a == TARGET);
        ctrl_start();
        chk("busy_after_start", bus.busy_o, 1'b1);
        xfer_byte({a, rw}, 1'b1, rb, ack);
        chk("addr_ack", ack, !match);
        if (match) model_rnw = rw;
        chk("rnw", bus.rnw_o, model_rnw);
        if (match && !rw) begin
            for (int i = 0; i < n; i++) begin
                xfer_byte(wbuf[i], 1'b1, rb, ack);
                chk("wr_ack", ack, !rrdy);
                if (!rrdy) break;
                exp_rx.push_back(wbuf[i]);
            end
        end
        if (match && rw) begin
            for (int i = 0; i < n; i++) begin
                xfer_byte(8'hFF, (i == n - 1), rb, ack);
                if (mq.size() != 0) begin
                    expb = mq.pop_front();
                    e_txr++;
                end else begin
                    expb = DEF_TX;
                    e_und++;
                end
                chk("rd_byte", rb, expb);
            end
        end
        if (stop_after) begin
            ctrl_stop();
            chk("stop_det", n_stop - p0, 1);
            chk("busy_after_stop", bus.busy_o, 1'b0);
        end
        chk("start_det", n_start - s0, 1);
        chk("addr_match", n_match - m0, match);
        chk("tx_ready", n_txr - t0, e_txr);
        chk("tx_underrun", n_und - u0, e_und);
        check_rx();
    endtask

    initial begin
        logic [7:0] rb;
        logic ack;
        logic [6:0] ra;
        bus.enable_i      = 1'b1;
        bus.target_addr_i = TARGET;
        bus.rx_ready_i    = 1'b1;
        bus.tx_valid_i    = 1'b0;
        bus.tx_data_i     = 8'h00;
        tick(4);
        rst_i = 1'b0;
        tick(2);
        chk("rst_sda", bus.sda_o, 1'b1);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_rnw", bus.rnw_o, 1'b0);
        chk("rst_rx_data", bus.rx_data_o, 8'h00);

        wbuf = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        xact(7'h50, 1'b0, 2, 1'b1, 1'b1, 1'b1);
        xact(7'h51, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        push_tx(8'h12);
        push_tx(8'h34);
        xact(7'h50, 1'b1, 2, 1'b1, 1'b1, 1'b1);
        xact(7'h50, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        wbuf[0] = 8'h11;
        xact(7'h50, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        push_tx(8'h5A);
        xact(7'h50, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        xact(7'h50, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        xact(7'h50, 1'b0, 1, 1'b0, 1'b1, 1'b1);

        // reset while the target is holding its address ACK low
        bus.enable_i = 1'b1;
        ctrl_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] ab;
            ab = {TARGET, 1'b0};
            bit_xfer(ab[i], ack);
        end
        chk("ack_driven", bus.sda_o, 1'b0);
        rst_i = 1'b1;
        tick(1);
        chk("midrst_sda", bus.sda_o, 1'b1);
        chk("midrst_busy", bus.busy_o, 1'b0);
        rst_i = 1'b0;
        model_rnw = 1'b0;
        ctrl_stop();
        got_rx.delete();
        wbuf = '{8'hC3, 8'h00, 8'h00, 8'h00};
        xact(7'h50, 1'b0, 1, 1'b1, 1'b1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? TARGET
                                              : 7'($urandom_range(0, 127));
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                push_tx(8'($urandom));
            xact(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
                 (k == 19) || ($urandom_range(0, 2) != 0));
        end
        tick(10);
        chk("end_idle_busy", bus.busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
